// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the sram port arbiter and its round-robin helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int MAX_RD         = 8;

    // Sized for the largest supported requester count, so one type serves
    // every NUM_RD instance without re-declaring it per parameterisation.
    localparam int RD_ID_W = $clog2(MAX_RD);
    typedef logic [RD_ID_W-1:0] rd_id_t;

    // Wrap a requester offset into 0..num_rd-1.
    function automatic rd_id_t rd_id_wrap(input int idx, input int num_rd);
        return rd_id_t'(idx % num_rd);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin candidate picker: first asserted request at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: pointer only moves when advance_i is high; a held-off candidate keeps its turn.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_RD = 2
) (
    input  logic [NUM_RD-1:0] req_i,
    input  rd_id_t            rr_ptr_i,
    input  logic              advance_i,
    output rd_id_t            cand_o,
    output logic              cand_vld_o,
    output rd_id_t            rr_ptr_nxt_o
);

    // Scan offsets 0..NUM_RD-1 from the pointer; the first hit wins. Only
    // constant bit-selects of req_i are used so the search unrolls cleanly.
    always_comb begin
        cand_o     = '0;
        cand_vld_o = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int j = 0; j < NUM_RD; j++) begin
                if (!cand_vld_o && req_i[j] &&
                    (rd_id_wrap(int'(rr_ptr_i) + k, NUM_RD) == rd_id_t'(j))) begin
                    cand_o     = rd_id_t'(j);
                    cand_vld_o = 1'b1;
                end
            end
        end
    end

    // Next pointer: one past the winner on a real grant, otherwise unchanged.
    always_comb begin
        rr_ptr_nxt_o = rr_ptr_i;
        if (advance_i && cand_vld_o) begin
            rr_ptr_nxt_o = rd_id_wrap(int'(cand_o) + 1, NUM_RD);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 1R/1W sram between NUM_RD round-robin readers and one always-granted writer.
// Latency: grants are combinational; rd_valid/rd_data follow the grant by one cycle.
// Backpressure: writes never stall; a read hitting this/last cycle's write address is held off.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         wr_req,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_gnt,
    output logic [ADDR_WIDTH-1:0]        sram_read_address,
    input  logic [DATA_WIDTH-1:0]        sram_read_data,
    output logic [ADDR_WIDTH-1:0]        sram_write_address,
    output logic [DATA_WIDTH-1:0]        sram_write_data,
    output logic                         sram_write_enable,
    output logic [CNT_WIDTH-1:0]         stall_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    rd_id_t                  rr_ptr_q;
    rd_id_t                  rr_ptr_d;
    logic                    last_wr_en_q;
    logic [ADDR_WIDTH-1:0]   last_wr_addr_q;
    logic [NUM_RD-1:0]       rd_valid_q;
    logic [CNT_WIDTH-1:0]    stall_cnt_q;
    logic [CNT_WIDTH-1:0]    stall_cnt_d;

    rd_id_t                  cand;
    logic                    cand_vld;
    logic [ADDR_WIDTH-1:0]   cand_addr;
    logic                    hazard;
    logic                    rd_go;

    // Write side: straight passthrough; the enable and grant are gated by
    // reset so nothing reaches the sram while the block is held in reset.
    assign wr_gnt             = reset & wr_req;
    assign sram_write_enable  = reset & wr_req;
    assign sram_write_address = wr_addr;
    assign sram_write_data    = wr_data;

    // Read data is shared; rd_valid tells each requester whose it is.
    assign rd_data  = sram_read_data;
    assign rd_valid = rd_valid_q;
    assign stall_count = stall_cnt_q;

    rr_arbiter #(
        .NUM_RD (NUM_RD)
    ) u_rr_arbiter (
        .req_i        (rd_req),
        .rr_ptr_i     (rr_ptr_q),
        .advance_i    (rd_go),
        .cand_o       (cand),
        .cand_vld_o   (cand_vld),
        .rr_ptr_nxt_o (rr_ptr_d)
    );

    // Select the candidate's address slice. Slices of non-requesting ports
    // are never picked, so X on an idle rd_addr cannot reach the compare.
    always_comb begin
        cand_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (cand_vld && (cand == rd_id_t'(i))) begin
                cand_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign sram_read_address = cand_addr;

    // Only the candidate is checked: on a hit the whole read port idles this
    // cycle rather than falling through to another requester, which keeps
    // the candidate's turn intact.
    always_comb begin
        hazard = 1'b0;
        if (cand_vld) begin
            hazard = (wr_req && (wr_addr == cand_addr)) ||
                     (last_wr_en_q && (last_wr_addr_q == cand_addr));
        end
    end

    assign rd_go = reset && cand_vld && !hazard;

    // One-hot grant to the candidate when the read is allowed through.
    always_comb begin
        rd_gnt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_gnt[i] = rd_go && (cand == rd_id_t'(i));
        end
    end

    // Saturating count of cycles a pending read lost to a hazard.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // State: pointer, previous-write tracking, valid pipeline, statistics.
    // Async clear of rd_valid_q drops any read in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q       <= '0;
            last_wr_en_q   <= 1'b0;
            last_wr_addr_q <= '0;
            rd_valid_q     <= '0;
            stall_cnt_q    <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            last_wr_en_q   <= wr_req;
            last_wr_addr_q <= wr_addr;
            rd_valid_q     <= rd_gnt;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-read/single-write-port sram between NUM_RD read requesters and one write requester, e.g. input-feature fetch, weight fetch and output store of the binary convolution datapath.
- Arbitrates reads round-robin.
- Guarantees the sram never sees a read that would return X: a read to the address written on the same cycle or the previous cycle is held off.
- Routes read data back to the winning requester with a valid strobe.

Parameters:
- ADDR_WIDTH, 32, sram address width; must match the sram instance.
- DATA_WIDTH, 16, sram data width.
- NUM_RD, 2, number of read requesters, 2..8.
- CNT_WIDTH, 16, width of the hazard-stall statistics counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  NUM_RD  per-requester read request, held until granted.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; requester i uses slice i.
- rd_gnt  out  NUM_RD  one-hot, combinational; address accepted this cycle.
- rd_valid  out  NUM_RD  one-hot, registered; rd_data is valid for that requester.
- rd_data  out  DATA_WIDTH  shared read data, passthrough of sram_read_data.
- wr_req  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_gnt  out  1  combinational; write accepted this cycle.
- sram_read_address  out  ADDR_WIDTH  to sram read_address.
- sram_read_data  in  DATA_WIDTH  from sram read_data.
- sram_write_address  out  ADDR_WIDTH  to sram write_address.
- sram_write_data  out  DATA_WIDTH  to sram write_data.
- sram_write_enable  out  1  to sram write_enable.
- stall_count  out  CNT_WIDTH  saturating count of read cycles lost to hazards.

Behaviour:
- Reset low (asynchronous): rd_valid=0, stall_count=0, rr_ptr=0, last_wr_en=0, last_wr_addr=0.
  - Combinational outputs are forced inactive during reset: rd_gnt=0, wr_gnt=0, sram_write_enable=0.
  - Reset mid-operation drops any in-flight read: no rd_valid follows.
- Write path has absolute priority and never stalls.
  - wr_gnt = wr_req.
  - sram_write_enable = wr_req.
  - sram_write_address and sram_write_data are direct from wr_addr and wr_data.
  - Registered every cycle: last_wr_en <= wr_req, last_wr_addr <= wr_addr.
- Read candidate: the first requester with rd_req high, searching from rr_ptr upward modulo NUM_RD.
  - sram_read_address = candidate address, or 0 if there is no candidate.
- Hazard, evaluated on the candidate address A: (wr_req && wr_addr==A) || (last_wr_en && last_wr_addr==A).
  - On hazard: rd_gnt=0 and stall_count increments, saturating at all-ones.
  - Other requesters are not tried that cycle, so the candidate keeps its turn.
- No hazard and a candidate exists: rd_gnt[cand]=1 and rr_ptr <= (cand+1) mod NUM_RD.
- Latency: grant in cycle N, then rd_valid[cand]=1 in cycle N+1 with rd_data = sram_read_data.
  - rd_valid is a registered copy of rd_gnt.
- Throughput: one read and one write per cycle, back-to-back.
- rr_ptr changes only on a grant; it does not advance on idle or stall cycles.
- A requester dropping rd_req before its grant is legal; it is simply not selected.
- rd_addr must be stable while rd_req is high and ungranted.
- Simultaneous write and read to different addresses: both granted in the same cycle.
- A hazard stall lasts at most 2 cycles after the last conflicting write.
  - A continuous stream of writes to address A starves reads of A; this is by design and documented for the datapath controller.
- X-safety: X on rd_addr while rd_req=0 must not influence grants.

Decomposition:
- Package sram_arb_pkg holds:
  - default ADDR_WIDTH and DATA_WIDTH;
  - the rd_id_t typedef, logic [$clog2(NUM_RD)-1:0];
  - MAX_RD = 8.
- Sub-module rr_arbiter (NUM_RD).
  - Inputs: req vector, rr_ptr, advance.
  - Outputs: candidate index and candidate-valid.
  - Reused later by the output-buffer scheduler.
- Hazard compare, write passthrough and the valid pipeline stay in the top module.

Test Plan:
- Single read: sram preloaded mem[0x10]=0xBEEF; rd_req[0]=1, addr 0x10 in cycle 1 -> rd_gnt[0]=1 in cycle 1; rd_valid[0]=1 and rd_data=0xBEEF in cycle 2; stall_count=0.
- Fairness: rd_req=2'b11 held with addresses 0x20/0x30 for 4 cycles -> grants alternate 0,1,0,1; rd_valid alternates one cycle later with the matching data.
- RAW, previous cycle: write 0x40=0x1234 in cycle 1; read 0x40 requested in cycle 2 -> no grant in cycle 2; grant in cycle 3; rd_data=0x1234 in cycle 4; stall_count=1.
- Same-cycle collision: wr_req with addr 0x50 and rd_req[1] with addr 0x50 in cycle 1, write only -> reads stalled in cycles 1-2; granted in cycle 3; data equals the new value; stall_count=2.
- Independent ports: write 0x60 and read 0x61 in the same cycle -> wr_gnt=1 and rd_gnt=1 together; no stall.
- Reset mid-operation: grant in cycle N, reset asserted asynchronously before edge N+1 -> rd_valid=0 immediately and stays 0; rr_ptr=0; stall_count=0 after release.
